// File: rtl/tristate_bus_monitor.sv
// Resolver for a shared tri-state bus with active-low enables, plus a clocked
// monitor: optional keeper, first-conflict log, saturating conflict counter, float watchdog.
module tristate_bus_monitor #(
  parameter int WIDTH       = 8,
  parameter int INPUT_COUNT = 2,
  parameter int KEEPER      = 0,
  parameter int ALLOW_EQUAL = 0,
  parameter int CNT_WIDTH   = 8,
  parameter int FLOAT_LIMIT = 16
) (
  input  logic                         i_clk,
  input  logic                         i_reset,
  input  logic [WIDTH*INPUT_COUNT-1:0] i_data,
  input  logic [INPUT_COUNT-1:0]       i_noe,
  input  logic                         i_clear,
  output logic [WIDTH-1:0]             o_data,
  output logic                         o_noe,
  output logic                         o_conflict,
  output logic                         o_conflict_sticky,
  output logic [INPUT_COUNT-1:0]       o_conflict_mask,
  output logic [CNT_WIDTH-1:0]         o_conflict_count,
  output logic                         o_float_timeout
);

  localparam logic [15:0] FLOAT_LIM = 16'(FLOAT_LIMIT);

  logic [INPUT_COUNT-1:0] active;
  logic [WIDTH-1:0]       and_c   [INPUT_COUNT+1];
  logic [WIDTH-1:0]       or_c    [INPUT_COUNT+1];
  logic                   any_c   [INPUT_COUNT+1];
  logic                   multi_c [INPUT_COUNT+1];

  logic [WIDTH-1:0]       and_v, or_v;
  logic                   any_act, multi_act;

  logic [WIDTH-1:0]       keep_q, keep_d;
  logic                   sticky_q, sticky_d;
  logic [INPUT_COUNT-1:0] mask_q, mask_d;
  logic [CNT_WIDTH-1:0]   count_q, count_d;
  logic [15:0]            float_q, float_d;
  logic                   timeout_q, timeout_d;

  assign and_c[0]   = '1;
  assign or_c[0]    = '0;
  assign any_c[0]   = 1'b0;
  assign multi_c[0] = 1'b0;

  // Per-driver reduction chain: AND gives the wired-AND value, AND==OR means
  // every active driver carries identical data.
  for (genvar g = 0; g < INPUT_COUNT; g++) begin : g_drv
    logic             act;
    logic [WIDTH-1:0] drv;

    assign drv = i_data[g*WIDTH +: WIDTH];

    // An if on ==0 treats X/Z enables as inactive in four-state simulation.
    always_comb begin
      act = 1'b0;
      if (i_noe[g] == 1'b0) act = 1'b1;
    end

    assign active[g]    = act;
    assign and_c[g+1]   = act ? (and_c[g] & drv) : and_c[g];
    assign or_c[g+1]    = act ? (or_c[g] | drv) : or_c[g];
    assign any_c[g+1]   = any_c[g] | act;
    assign multi_c[g+1] = multi_c[g] | (any_c[g] & act);
  end

  assign and_v     = and_c[INPUT_COUNT];
  assign or_v      = or_c[INPUT_COUNT];
  assign any_act   = any_c[INPUT_COUNT];
  assign multi_act = multi_c[INPUT_COUNT];

  assign o_conflict = multi_act && !((ALLOW_EQUAL != 0) && (and_v == or_v));
  assign o_noe      = !any_act || o_conflict;
  assign o_data     = any_act ? and_v : ((KEEPER != 0) ? keep_q : '1);

  always_comb begin
    keep_d = keep_q;
    if (!o_noe) keep_d = o_data;

    sticky_d  = i_clear ? 1'b0 : sticky_q;
    mask_d    = i_clear ? '0 : mask_q;
    count_d   = i_clear ? '0 : count_q;
    float_d   = i_clear ? '0 : float_q;
    timeout_d = i_clear ? 1'b0 : timeout_q;

    // Clear and a same-edge conflict: the cleared values feed the set path.
    if (o_conflict) begin
      if (!sticky_d) mask_d = active;
      sticky_d = 1'b1;
      if (count_d != '1) count_d = count_d + CNT_WIDTH'(1);
    end

    if (any_act) begin
      float_d = '0;
    end else if (float_d != FLOAT_LIM) begin
      float_d = float_d + 16'd1;
    end
    if (float_d == FLOAT_LIM) timeout_d = 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      keep_q    <= '1;
      sticky_q  <= 1'b0;
      mask_q    <= '0;
      count_q   <= '0;
      float_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      keep_q    <= keep_d;
      sticky_q  <= sticky_d;
      mask_q    <= mask_d;
      count_q   <= count_d;
      float_q   <= float_d;
      timeout_q <= timeout_d;
    end
  end

  assign o_conflict_sticky = sticky_q;
  assign o_conflict_mask   = mask_q;
  assign o_conflict_count  = count_q;
  assign o_float_timeout   = timeout_q;

endmodule

// File: tb/tb_tristate_bus_monitor.sv
// Bench for tristate_bus_monitor: four parameterisations sharing clock and reset,
// expectations queued at stimulus time and compared once outputs are valid.
module tb_tristate_bus_monitor;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // u_keep: KEEPER=1
  logic [15:0] k_data = '0; logic [1:0] k_noe = '1; logic k_clr = 1'b0;
  logic [7:0]  k_odata; logic k_onoe, k_oconf, k_sticky, k_tmo; logic [1:0] k_mask; logic [7:0] k_cnt;
  // u_c3: three drivers, defaults otherwise
  logic [23:0] c_data = '0; logic [2:0] c_noe = '1; logic c_clr = 1'b0;
  logic [7:0]  c_odata; logic c_onoe, c_oconf, c_sticky, c_tmo; logic [2:0] c_mask; logic [7:0] c_cnt;
  // u_eq: ALLOW_EQUAL=1
  logic [15:0] e_data = '0; logic [1:0] e_noe = '1; logic e_clr = 1'b0;
  logic [7:0]  e_odata; logic e_onoe, e_oconf, e_sticky, e_tmo; logic [1:0] e_mask; logic [7:0] e_cnt;
  // u_sat: CNT_WIDTH=2, FLOAT_LIMIT=4
  logic [15:0] s_data = '0; logic [1:0] s_noe = '1; logic s_clr = 1'b0;
  logic [7:0]  s_odata; logic s_onoe, s_oconf, s_sticky, s_tmo; logic [1:0] s_mask; logic [1:0] s_cnt;

  tristate_bus_monitor #(.WIDTH(8), .INPUT_COUNT(2), .KEEPER(1)) u_keep (
    .i_clk(clk), .i_reset(rst), .i_data(k_data), .i_noe(k_noe), .i_clear(k_clr),
    .o_data(k_odata), .o_noe(k_onoe), .o_conflict(k_oconf), .o_conflict_sticky(k_sticky),
    .o_conflict_mask(k_mask), .o_conflict_count(k_cnt), .o_float_timeout(k_tmo));

  tristate_bus_monitor #(.WIDTH(8), .INPUT_COUNT(3)) u_c3 (
    .i_clk(clk), .i_reset(rst), .i_data(c_data), .i_noe(c_noe), .i_clear(c_clr),
    .o_data(c_odata), .o_noe(c_onoe), .o_conflict(c_oconf), .o_conflict_sticky(c_sticky),
    .o_conflict_mask(c_mask), .o_conflict_count(c_cnt), .o_float_timeout(c_tmo));

  tristate_bus_monitor #(.WIDTH(8), .INPUT_COUNT(2), .ALLOW_EQUAL(1)) u_eq (
    .i_clk(clk), .i_reset(rst), .i_data(e_data), .i_noe(e_noe), .i_clear(e_clr),
    .o_data(e_odata), .o_noe(e_onoe), .o_conflict(e_oconf), .o_conflict_sticky(e_sticky),
    .o_conflict_mask(e_mask), .o_conflict_count(e_cnt), .o_float_timeout(e_tmo));

  tristate_bus_monitor #(.WIDTH(8), .INPUT_COUNT(2), .KEEPER(0), .CNT_WIDTH(2), .FLOAT_LIMIT(4)) u_sat (
    .i_clk(clk), .i_reset(rst), .i_data(s_data), .i_noe(s_noe), .i_clear(s_clr),
    .o_data(s_odata), .o_noe(s_onoe), .o_conflict(s_oconf), .o_conflict_sticky(s_sticky),
    .o_conflict_mask(s_mask), .o_conflict_count(s_cnt), .o_float_timeout(s_tmo));

  typedef enum int {
    K_DATA, K_NOE,
    C_DATA, C_NOE, C_CONF, C_STICKY, C_MASK, C_COUNT, C_TMO,
    E_DATA, E_NOE, E_CONF, E_STICKY, E_COUNT,
    S_DATA, S_NOE, S_CONF, S_STICKY, S_MASK, S_COUNT, S_TMO
  } sig_e;

  typedef struct {
    string       tag;
    sig_e        sig;
    logic [31:0] val;
  } exp_t;

  typedef struct {
    logic [2:0]  noe;
    logic [23:0] data;
    logic [7:0]  exp_data;
    logic        exp_noe;
    logic        exp_conf;
  } vec_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  function automatic logic [31:0] get_act(input sig_e s);
    case (s)
      K_DATA:   return 32'(k_odata);
      K_NOE:    return 32'(k_onoe);
      C_DATA:   return 32'(c_odata);
      C_NOE:    return 32'(c_onoe);
      C_CONF:   return 32'(c_oconf);
      C_STICKY: return 32'(c_sticky);
      C_MASK:   return 32'(c_mask);
      C_COUNT:  return 32'(c_cnt);
      C_TMO:    return 32'(c_tmo);
      E_DATA:   return 32'(e_odata);
      E_NOE:    return 32'(e_onoe);
      E_CONF:   return 32'(e_oconf);
      E_STICKY: return 32'(e_sticky);
      E_COUNT:  return 32'(e_cnt);
      S_DATA:   return 32'(s_odata);
      S_NOE:    return 32'(s_onoe);
      S_CONF:   return 32'(s_oconf);
      S_STICKY: return 32'(s_sticky);
      S_MASK:   return 32'(s_mask);
      S_COUNT:  return 32'(s_cnt);
      S_TMO:    return 32'(s_tmo);
      default:  return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic expect_val(input string tag, input sig_e s, input logic [31:0] v);
    exp_t e;
    e.tag = tag; e.sig = s; e.val = v;
    sb.push_back(e);
  endtask

  task automatic check_all();
    exp_t e;
    logic [31:0] a;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      a = get_act(e.sig);
      n_checks++;
      if (a !== e.val) $display("FAIL %s/%s: got %0h expected %0h", e.tag, e.sig.name(), a, e.val);
      else n_pass++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  vec_t tbl[7];

  initial begin
    tbl[0] = '{3'b111, 24'h123456, 8'hFF, 1'b1, 1'b0};
    tbl[1] = '{3'b110, 24'h00003C, 8'h3C, 1'b0, 1'b0};
    tbl[2] = '{3'b011, 24'h81FFFF, 8'h81, 1'b0, 1'b0};
    tbl[3] = '{3'b010, 24'hF5000F, 8'h05, 1'b1, 1'b1};
    tbl[4] = '{3'b000, 24'hF5FF0F, 8'h05, 1'b1, 1'b1};
    tbl[5] = '{3'b100, 24'h00AAAA, 8'hAA, 1'b1, 1'b1};
    tbl[6] = '{3'b101, 24'hFF5AFF, 8'h5A, 1'b0, 1'b0};

    // Combinational resolution, applied while reset is held.
    for (int i = 0; i < 7; i++) begin
      c_noe = tbl[i].noe; c_data = tbl[i].data;
      expect_val($sformatf("tbl%0d", i), C_DATA, 32'(tbl[i].exp_data));
      expect_val($sformatf("tbl%0d", i), C_NOE,  32'(tbl[i].exp_noe));
      expect_val($sformatf("tbl%0d", i), C_CONF, 32'(tbl[i].exp_conf));
      #1 check_all();
    end

    c_noe = '1; k_noe = '1; e_noe = '1; s_noe = '1;
    expect_val("rst", C_STICKY, 0); expect_val("rst", C_MASK, 0);
    expect_val("rst", C_COUNT, 0);  expect_val("rst", C_TMO, 0);
    expect_val("rst", S_STICKY, 0); expect_val("rst", S_COUNT, 0);
    expect_val("rst", K_DATA, 32'hFF); expect_val("rst", K_NOE, 1);
    tick(); check_all();
    rst = 1'b0;

    // Keeper holds the last validly driven value.
    k_noe = 2'b10; k_data = 16'h003C;
    expect_val("keep_drv", K_DATA, 32'h3C); expect_val("keep_drv", K_NOE, 0);
    #1 check_all();
    tick();
    k_noe = 2'b11;
    expect_val("keep_rel", K_DATA, 32'h3C); expect_val("keep_rel", K_NOE, 1);
    #1 check_all();
    tick();
    expect_val("keep_hold", K_DATA, 32'h3C);
    check_all();

    // Two-edge conflict on drivers 0 and 2, then first-mask preservation and clear.
    c_noe = 3'b010; c_data = 24'hF5000F;
    expect_val("c3_conf", C_DATA, 32'h05); expect_val("c3_conf", C_CONF, 1);
    #1 check_all();
    tick(); tick();
    expect_val("c3_log", C_STICKY, 1); expect_val("c3_log", C_MASK, 32'h5); expect_val("c3_log", C_COUNT, 2);
    check_all();
    c_noe = 3'b100; c_data = 24'hF5330F;
    tick();
    expect_val("c3_keepmask", C_MASK, 32'h5); expect_val("c3_keepmask", C_COUNT, 3);
    check_all();
    c_clr = 1'b1;
    tick();
    expect_val("c3_clrconf", C_STICKY, 1); expect_val("c3_clrconf", C_MASK, 32'h3); expect_val("c3_clrconf", C_COUNT, 1);
    check_all();
    c_noe = 3'b110;
    tick();
    c_clr = 1'b0;
    expect_val("c3_clr", C_STICKY, 0); expect_val("c3_clr", C_MASK, 0); expect_val("c3_clr", C_COUNT, 0);
    check_all();

    // Equal data is not a conflict when ALLOW_EQUAL=1, differing data still is.
    e_noe = 2'b00; e_data = 16'hA5A5;
    expect_val("eq_same", E_DATA, 32'hA5); expect_val("eq_same", E_NOE, 0); expect_val("eq_same", E_CONF, 0);
    #1 check_all();
    tick();
    expect_val("eq_nolog", E_STICKY, 0); expect_val("eq_nolog", E_COUNT, 0);
    check_all();
    e_data = 16'hA5A4;
    expect_val("eq_diff", E_DATA, 32'hA4); expect_val("eq_diff", E_CONF, 1); expect_val("eq_diff", E_NOE, 1);
    #1 check_all();
    tick();
    expect_val("eq_difflog", E_COUNT, 1);
    check_all();
    e_noe = 2'b0x; e_data = 16'h1212;
    expect_val("xnoe", E_DATA, 32'h12); expect_val("xnoe", E_NOE, 0); expect_val("xnoe", E_CONF, 0);
    #1 check_all();

    // Equal data conflicts with ALLOW_EQUAL=0; 2-bit counter saturates at 3.
    s_noe = 2'b00; s_data = 16'hA5A5;
    expect_val("ne_conf", S_DATA, 32'hA5); expect_val("ne_conf", S_CONF, 1); expect_val("ne_conf", S_NOE, 1);
    #1 check_all();
    tick();
    expect_val("ne_log", S_COUNT, 1); expect_val("ne_log", S_STICKY, 1); expect_val("ne_log", S_MASK, 32'h3);
    check_all();
    for (int i = 2; i <= 5; i++) begin
      tick();
      expect_val($sformatf("sat%0d", i), S_COUNT, (i > 3) ? 32'd3 : 32'(i));
      check_all();
    end
    s_data = 16'hF00F; s_clr = 1'b1;
    expect_val("sat_and", S_DATA, 32'h00);
    #1 check_all();
    tick();
    expect_val("sat_clrconf", S_COUNT, 1); expect_val("sat_clrconf", S_MASK, 32'h3); expect_val("sat_clrconf", S_STICKY, 1);
    check_all();

    // Float watchdog: fires on the 4th undriven edge and stays set until cleared.
    s_noe = 2'b10;
    tick();
    s_clr = 1'b0;
    expect_val("fl_clr", S_STICKY, 0); expect_val("fl_clr", S_COUNT, 0); expect_val("fl_clr", S_TMO, 0);
    check_all();
    s_noe = 2'b11;
    expect_val("fl_pull", S_DATA, 32'hFF); expect_val("fl_pull", S_NOE, 1);
    #1 check_all();
    for (int i = 1; i <= 5; i++) begin
      tick();
      expect_val($sformatf("fl_edge%0d", i), S_TMO, (i >= 4) ? 32'd1 : 32'd0);
      check_all();
    end
    s_noe = 2'b10;
    tick();
    expect_val("fl_driven", S_TMO, 1);
    check_all();
    s_clr = 1'b1;
    tick();
    expect_val("fl_cleared", S_TMO, 0);
    check_all();
    s_noe = 2'b11;
    tick();
    s_clr = 1'b0;
    for (int i = 2; i <= 4; i++) begin
      tick();
      expect_val($sformatf("fl_clridle%0d", i), S_TMO, (i == 4) ? 32'd1 : 32'd0);
      check_all();
    end

    // Reset asserted in the middle of a conflict.
    c_noe = 3'b010; c_data = 24'hF5000F;
    tick();
    expect_val("pre_rst", C_STICKY, 1); expect_val("pre_rst", K_DATA, 32'h3C);
    check_all();
    rst = 1'b1;
    tick();
    expect_val("mid_rst", C_STICKY, 0); expect_val("mid_rst", C_MASK, 0);
    expect_val("mid_rst", C_COUNT, 0);  expect_val("mid_rst", C_TMO, 0);
    expect_val("mid_rst", C_CONF, 1);   expect_val("mid_rst", K_DATA, 32'hFF);
    check_all();
    rst = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/tristate_bus_monitor.md
# tristate_bus_monitor

Parametrised resolver and monitor for a shared multi-driver bus in the TTL-level simulation model. It merges up to INPUT_COUNT tri-state drivers with active-low output enables onto one WIDTH-bit bus. A clocked monitor adds an optional bus keeper, per-event contention logging, a saturating contention counter and a floating-bus watchdog. It sits wherever several chip models share a bus (data bus, ALU bus), in place of ad-hoc per-net resolution.

## Interface

Parameters:

- WIDTH, 8, bus width in bits
- INPUT_COUNT, 2, number of drivers (≥1)
- KEEPER, 0, 1 = undriven bus holds last driven value; 0 = undriven bus reads all ones (pull-up)
- ALLOW_EQUAL, 0, 1 = several drivers with identical data is not a conflict
- CNT_WIDTH, 8, width of contention counter
- FLOAT_LIMIT, 16, consecutive undriven cycles before watchdog fires (≥1, < 2^16)

Ports:

- i_clk  in  1  clock, rising edge
- i_reset  in  1  synchronous, active-high reset
- i_data  in  WIDTH*INPUT_COUNT  driver data; driver k at bits [k*WIDTH +: WIDTH]
- i_noe  in  INPUT_COUNT  active-low output enables
- i_clear  in  1  clears sticky/log state (synchronous)
- o_data  out  WIDTH  resolved bus value (combinational)
- o_noe  out  1  0 when the bus is validly driven this cycle (combinational)
- o_conflict  out  1  conflict in current cycle (combinational)
- o_conflict_sticky  out  1  registered, set on any sampled conflict
- o_conflict_mask  out  INPUT_COUNT  registered, enables (active-high) of the first logged conflict
- o_conflict_count  out  CNT_WIDTH  registered, saturating count of conflict cycles
- o_float_timeout  out  1  registered, undriven for ≥FLOAT_LIMIT consecutive cycles

## Operation

- Driver k is active iff i_noe[k] is exactly 0. X/Z on i_noe[k] means inactive.
- n = number of active drivers.
- n==0: o_data = keep_reg if KEEPER=1, else all ones. o_noe=1, o_conflict=0.
- n==1: o_data = that driver's data. o_noe=0, o_conflict=0.
- n>1, all active data identical, ALLOW_EQUAL=1: o_data = common value. o_noe=0, o_conflict=0.
- n>1 otherwise: o_data = bitwise AND of all active drivers (wired-AND, low wins). o_noe=1, o_conflict=1.
- keep_reg: loaded with o_data on each edge where o_noe==0. Otherwise holds.
- Conflict log, on each edge with o_conflict=1:
  - o_conflict_sticky←1
  - o_conflict_count increments, saturating at 2^CNT_WIDTH−1
  - o_conflict_mask captured only if sticky was 0 before the edge, so the first conflict after a clear is preserved
- Float watchdog, internal 16-bit counter:
  - counts edges with n==0; resets to 0 on any edge with n≥1
  - o_float_timeout←1 when the counter reaches FLOAT_LIMIT
  - counter saturates at FLOAT_LIMIT
  - flag is sticky until i_clear or reset, even after the bus is driven again
- i_clear=1: sticky, mask, count, float counter and timeout cleared on the edge.
  - If a conflict is present on the same edge, the set wins: sticky=1, count=1, mask=current enables.
  - If n==0 on the same edge, the float counter becomes 1.
  - keep_reg is not affected by i_clear.

## Timing

- o_data, o_noe, o_conflict: zero-latency combinational from i_data, i_noe and keep_reg.
- Registered outputs update on the rising edge following the sampled condition (1-cycle latency).
- Reset takes precedence over i_clear and over all events. After the reset edge:
  - keep_reg = all ones
  - o_conflict_sticky=0, o_conflict_mask=0, o_conflict_count=0
  - float counter=0, o_float_timeout=0
- Reset does not gate the combinational outputs.
- A conflict shorter than one clock period that does not straddle an edge is visible only on o_conflict. It is not logged.

## Test plan

- Reset, KEEPER=1, WIDTH=8, no drivers -> o_data=0xFF, o_noe=1. Drive k0=0x3C for 1 cycle, then release -> o_data stays 0x3C, o_noe=1.
- INPUT_COUNT=3, drivers 0x0F and 0xF5 enabled on drivers 0 and 2 for 2 edges -> o_data=0x05, o_conflict=1, sticky=1, mask=3'b101, count=2.
- ALLOW_EQUAL=1, two drivers both 0xA5 -> o_noe=0, o_data=0xA5, no conflict logged. Repeat with ALLOW_EQUAL=0 -> conflict, count=1.
- CNT_WIDTH=2, 5 consecutive conflict edges -> count saturates at 3. i_clear asserted together with a conflict on drivers {1} and {0} -> count=1, mask reflects the new enables.
- FLOAT_LIMIT=4, KEEPER=0 -> timeout asserts after the 4th undriven edge, not the 3rd. Driving the bus keeps the timeout at 1. i_clear drops it to 0.
- i_noe[0]=X with driver 1 enabled at 0x12 -> o_data=0x12, o_noe=0, no conflict. Reset asserted mid-conflict -> all registered outputs 0 on the next edge.
